cook_timer_ctrl: RTL and testbench
==================================

# cook_timer_ctrl

Sequencer for the microwave magnetron. Accepts a cook time entered digit-by-digit as BCD mm:ss. Counts it down at a divided 1 Hz tick while cooking. Drives `mag_on` directly and raises `timer_done` on expiry. Replaces the free-standing set/reset latch path: front-panel buttons and the door switch feed this block, and the magnetron enable comes from its state.

## Interface
- `TICK_DIV`, default 50_000_000: `clk` cycles per countdown second; minimum 2.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `starn`  in  1  start button, active-low; synchronous to `clk`.
- `stopn`  in  1  stop/pause button, active-low.
- `clearn`  in  1  clear/cancel button, active-low.
- `door_closed`  in  1  door switch; 1 = closed.
- `digit_valid`  in  1  one-cycle strobe: `digit` holds a keypad entry.
- `digit`  in  4  keypad value; 0–9 valid, 10–15 ignored.
- `mag_on`  out  1  magnetron enable.
- `timer_done`  out  1  cook time expired.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  BCD display of remaining time.
- `state`  out  3  current FSM state code, for display and debug.

## Operation
- **Press detection:** a press is a 1→0 transition of `starn`, `stopn` or `clearn`, detected against a one-cycle registered copy. Holding a button low produces one press.
- **Press priority in one cycle:** clear > stop > door open > start.
- **FSM states:** IDLE=0, COOK=1, PAUSE=2, DONE=3.
- **IDLE:**
  - A valid `digit_valid` shifts the display left: `min_tens`←`min_ones`←`sec_tens`←`sec_ones`←`digit`.
  - The shift is rejected, leaving the display unchanged, if `digit`>9 or current `sec_ones`>5. This keeps `sec_tens` ≤5.
  - Start with `door_closed`=1 and time ≠ 00:00 → COOK; tick counter cleared.
  - Start under any other condition is ignored.
  - Clear zeroes all digits.
- **COOK:**
  - Tick counter runs 0..`TICK_DIV`-1. At terminal count it wraps to 0 and mm:ss decrements by one second.
  - BCD borrow chain: `sec_ones` 0→9 borrows `sec_tens`; `sec_tens` 0→5 borrows `min_ones`; `min_ones` 0→9 borrows `min_tens`.
  - A decrement that reaches 00:00 → DONE on the same edge.
  - Clear → IDLE with 00:00. Stop or `door_closed`=0 → PAUSE.
  - If any exit condition coincides with a tick, the decrement is not applied.
  - Digit entry is ignored.
- **PAUSE:**
  - Tick counter and digits are held.
  - Start with door closed → COOK, with the tick counter resuming from its held value.
  - Clear → IDLE with 00:00.
  - Digit entry is ignored.
- **DONE:**
  - `timer_done`=1 and display shows 00:00.
  - Clear, start, or `door_closed`=0 → IDLE.
- **`mag_on` definition:** `mag_on` = (state==COOK) AND `door_closed`. This is the only combinational path from an input to an output, and it guarantees door-open cutoff with zero latency.
- **`timer_done`:** equals (state==DONE), decoded from the state register.
- **Reset:** state=IDLE, all digits 0, tick counter 0, press-detect registers = 1 (released), `mag_on`=0, `timer_done`=0.

## Timing
- Start press sampled at edge N → `state`=COOK and `mag_on`=1 after edge N.
- First decrement occurs after edge N+`TICK_DIV`.
- Door opening: `mag_on` falls in the same cycle; `state`=PAUSE after the next edge.
- Stop: `mag_on` falls after the edge that samples the press.
- Maximum time is 99:59 = 5999 ticks, with no overflow path. A decrement at 00:00 cannot occur.
- `rst` asserted mid-COOK: `mag_on`=0 after that edge and all state is as at reset. `rst` overrides every other input.
- A digit entry is visible on the display after the sampling edge.

## Structure
- **Shared package `microwave_pkg`:**
  - state encoding constants IDLE/COOK/PAUSE/DONE;
  - BCD limit constants 9 and 5;
  - 3-bit state width.
- **Sub-module `mmss_bcd_down`:** four-digit register with shift-load and decrement-with-borrow. Ports: clk, rst, clr, shift_en, shift_digit, dec_en, the four digits, is_zero.
- **Top level:** FSM, tick divider (`$clog2(TICK_DIV)` bits), press detectors and `mag_on` gating.

## Test plan
All scenarios use `TICK_DIV`=4.
- Enter 1,3,0 → display 01:30; start → `mag_on`=1; after 90×4 cycles → 00:00, `timer_done`=1, `mag_on`=0.
- Set 01:00, start; the first tick gives 00:59 (borrow chain). Set 10:00 → first tick gives 09:59.
- Set 00:05, start, open door after 2 ticks → `mag_on`=0 in the same cycle, state PAUSE, display 00:03. Close door → no resume. Start → resumes and finishes.
- Display 00:07, enter digit 4 → rejected (`sec_ones`>5), display stays 00:07. Enter digit 12 → ignored.
- Start with time 00:00, and start with door open → state stays IDLE, `mag_on`=0.
- Clear, stop and start pressed in the same cycle during COOK → IDLE at 00:00. `rst` mid-COOK → all outputs return to their reset values.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared constants for the microwave cook-timer: FSM state codes and BCD digit limits.
package microwave_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] COOK  = 3'd1;
    localparam logic [STATE_W-1:0] PAUSE = 3'd2;
    localparam logic [STATE_W-1:0] DONE  = 3'd3;

    localparam logic [3:0] BCD_MAX_ONES = 4'd9;
    localparam logic [3:0] BCD_MAX_TENS = 4'd5;

endpackage

// File: rtl/mmss_bcd_down.sv
// Four-digit BCD mm:ss register: left-shift keypad load and one-second decrement with borrow.
module mmss_bcd_down
    import microwave_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       shift_en,
    input  logic [3:0] shift_digit,
    input  logic       dec_en,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       is_zero
);

    assign is_zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                     (sec_tens == 4'd0) && (sec_ones == 4'd0);

    // NOTE: clocked state is updated with non-blocking (<=) assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
        end else if (shift_en) begin
            min_tens <= min_ones;
            min_ones <= sec_tens;
            sec_tens <= sec_ones;
            sec_ones <= shift_digit;
        end else if (dec_en && !is_zero) begin
            // Borrow ripples leftwards only while the lower digit is already zero.
            if (sec_ones != 4'd0) begin
                sec_ones <= sec_ones - 4'd1;
            end else begin
                sec_ones <= BCD_MAX_ONES;
                if (sec_tens != 4'd0) begin
                    sec_tens <= sec_tens - 4'd1;
                end else begin
                    sec_tens <= BCD_MAX_TENS;
                    if (min_ones != 4'd0) begin
                        min_ones <= min_ones - 4'd1;
                    end else begin
                        min_ones <= BCD_MAX_ONES;
                        min_tens <= min_tens - 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/cook_timer_ctrl.sv
// Magnetron sequencer: keypad time entry, 1 Hz countdown, start/stop/clear/door FSM.
module cook_timer_ctrl
    import microwave_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               starn,
    input  logic               stopn,
    input  logic               clearn,
    input  logic               door_closed,
    input  logic               digit_valid,
    input  logic [3:0]         digit,
    output logic               mag_on,
    output logic               timer_done,
    output logic [3:0]         min_tens,
    output logic [3:0]         min_ones,
    output logic [3:0]         sec_tens,
    output logic [3:0]         sec_ones,
    output logic [STATE_W-1:0] state
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic               starn_q, stopn_q, clearn_q;
    logic               start_press, stop_press, clear_press;
    logic [TICK_W-1:0]  tick_cnt;
    logic               tick_term;
    logic               time_zero, time_one;
    logic [STATE_W-1:0] state_next;
    logic               dig_clr, dig_shift, dig_dec;
    logic               tick_clr, tick_run;

    assign start_press = starn_q  & ~starn;
    assign stop_press  = stopn_q  & ~stopn;
    assign clear_press = clearn_q & ~clearn;
    assign tick_term   = (tick_cnt == TICK_LAST);
    assign time_one    = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                         (sec_tens == 4'd0) && (sec_ones == 4'd1);

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        dig_clr    = 1'b0;
        dig_shift  = 1'b0;
        dig_dec    = 1'b0;
        tick_clr   = 1'b0;
        tick_run   = 1'b0;
        case (state)
            IDLE: begin
                if (clear_press) begin
                    dig_clr = 1'b1;
                end else begin
                    dig_shift = digit_valid && (digit <= BCD_MAX_ONES) &&
                                (sec_ones <= BCD_MAX_TENS);
                    if (start_press && door_closed && !time_zero) begin
                        state_next = COOK;
                        tick_clr   = 1'b1;
                    end
                end
            end
            COOK: begin
                if (clear_press) begin
                    state_next = IDLE;
                    dig_clr    = 1'b1;
                end else if (stop_press || !door_closed) begin
                    state_next = PAUSE;
                end else begin
                    tick_run = 1'b1;
                    dig_dec  = tick_term;
                    if (tick_term && time_one) state_next = DONE;
                end
            end
            PAUSE: begin
                if (clear_press) begin
                    state_next = IDLE;
                    dig_clr    = 1'b1;
                end else if (!stop_press && start_press && door_closed) begin
                    state_next = COOK;
                end
            end
            DONE: begin
                if (clear_press || start_press || !door_closed) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            starn_q  <= 1'b1;
            stopn_q  <= 1'b1;
            clearn_q <= 1'b1;
        end else begin
            state    <= state_next;
            starn_q  <= starn;
            stopn_q  <= stopn;
            clearn_q <= clearn;
            if (tick_clr)
                tick_cnt <= '0;
            else if (tick_run)
                tick_cnt <= tick_term ? '0 : tick_cnt + 1'b1;
        end
    end

    mmss_bcd_down u_digits (
        .clk         (clk),
        .rst         (rst),
        .clr         (dig_clr),
        .shift_en    (dig_shift),
        .shift_digit (digit),
        .dec_en      (dig_dec),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .is_zero     (time_zero)
    );

    // Door switch gates the magnetron combinationally for zero-latency cutoff.
    assign mag_on     = (state == COOK) && door_closed;
    assign timer_done = (state == DONE);

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Directed self-checking bench for cook_timer_ctrl with TICK_DIV = 4.
module tb_cook_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       starn, stopn, clearn, door_closed, digit_valid;
    logic [3:0] digit;
    logic       mag_on, timer_done;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    cook_timer_ctrl #(.TICK_DIV(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .starn       (starn),
        .stopn       (stopn),
        .clearn      (clearn),
        .door_closed (door_closed),
        .digit_valid (digit_valid),
        .digit       (digit),
        .mag_on      (mag_on),
        .timer_done  (timer_done),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic s, input logic p, input logic c);
        starn  = ~s;
        stopn  = ~p;
        clearn = ~c;
        step(1);
        starn  = 1'b1;
        stopn  = 1'b1;
        clearn = 1'b1;
    endtask

    task automatic enter(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        step(1);
        digit_valid = 1'b0;
        digit       = 4'd0;
    endtask

    function automatic logic [31:0] disp();
        return {16'd0, min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    initial begin
        rst = 1'b1; starn = 1'b1; stopn = 1'b1; clearn = 1'b1;
        door_closed = 1'b1; digit_valid = 1'b0; digit = 4'd0;
        step(2);
        rst = 1'b0;
        check("reset_state", 32'(state), 32'd0);
        check("reset_disp", disp(), 32'h0000);
        check("reset_mag", 32'(mag_on), 32'd0);
        check("reset_done", 32'(timer_done), 32'd0);

        // 01:30 full countdown
        enter(4'd1); enter(4'd3); enter(4'd0);
        check("entry_0130", disp(), 32'h0130);
        press(1, 0, 0);
        check("start_state", 32'(state), 32'd1);
        check("start_mag", 32'(mag_on), 32'd1);
        step(359);
        check("cook_0001", disp(), 32'h0001);
        check("cook_0001_state", 32'(state), 32'd1);
        step(1);
        check("expire_disp", disp(), 32'h0000);
        check("expire_state", 32'(state), 32'd3);
        check("expire_done", 32'(timer_done), 32'd1);
        check("expire_mag", 32'(mag_on), 32'd0);
        press(0, 0, 1);
        check("done_clear", 32'(state), 32'd0);

        // Borrow chains
        enter(4'd1); enter(4'd0); enter(4'd0);
        press(1, 0, 0);
        step(3);
        check("pre_tick_0100", disp(), 32'h0100);
        step(1);
        check("borrow_0059", disp(), 32'h0059);
        press(0, 0, 1);
        check("cook_clear", disp(), 32'h0000);
        enter(4'd1); enter(4'd0); enter(4'd0); enter(4'd0);
        check("entry_1000", disp(), 32'h1000);
        press(1, 0, 0);
        step(4);
        check("borrow_0959", disp(), 32'h0959);
        press(0, 0, 1);

        // Door open pause and resume
        enter(4'd5);
        press(1, 0, 0);
        step(8);
        check("door_pre_0003", disp(), 32'h0003);
        door_closed = 1'b0;
        #1;
        check("door_mag_cut", 32'(mag_on), 32'd0);
        step(1);
        check("door_pause", 32'(state), 32'd2);
        check("door_hold", disp(), 32'h0003);
        door_closed = 1'b1;
        step(2);
        check("close_no_resume", 32'(state), 32'd2);
        press(1, 0, 0);
        check("resume_state", 32'(state), 32'd1);
        step(11);
        check("resume_0001", disp(), 32'h0001);
        step(1);
        check("resume_done", 32'(state), 32'd3);
        door_closed = 1'b0;
        step(1);
        check("done_door_idle", 32'(state), 32'd0);
        door_closed = 1'b1;

        // Digit rejection
        enter(4'd7);
        enter(4'd4);
        check("reject_sec_ones", disp(), 32'h0007);
        enter(4'd12);
        check("reject_12_a", disp(), 32'h0007);
        press(0, 0, 1);
        enter(4'd5); enter(4'd12);
        check("reject_12_b", disp(), 32'h0005);
        press(0, 0, 1);

        // Ignored starts
        press(1, 0, 0);
        check("start_zero", 32'(state), 32'd0);
        check("start_zero_mag", 32'(mag_on), 32'd0);
        enter(4'd2);
        door_closed = 1'b0;
        press(1, 0, 0);
        check("start_door_open", 32'(state), 32'd0);
        door_closed = 1'b1;
        step(1);
        check("door_open_mag", 32'(mag_on), 32'd0);

        // Simultaneous clear/stop/start during COOK
        press(1, 0, 0);
        step(2);
        press(1, 1, 1);
        check("multi_state", 32'(state), 32'd0);
        check("multi_disp", disp(), 32'h0000);

        // Stop, resume, then reset mid-cook
        enter(4'd3);
        press(1, 0, 0);
        step(1);
        press(0, 1, 0);
        check("stop_pause", 32'(state), 32'd2);
        check("stop_mag", 32'(mag_on), 32'd0);
        press(1, 0, 0);
        check("stop_resume", 32'(state), 32'd1);
        step(1);
        rst = 1'b1;
        step(1);
        check("rst_state", 32'(state), 32'd0);
        check("rst_disp", disp(), 32'h0000);
        check("rst_mag", 32'(mag_on), 32'd0);
        check("rst_done", 32'(timer_done), 32'd0);
        rst = 1'b0;
        step(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
